zoh_top_pipelined: RTL and testbench
====================================

# zoh_top_pipelined

Pipelined zero-order-hold (ZOH) interpolation datapath. It receives 16-bit signed audio samples from an I2S-style serial link (left channel only) and holds the latest sample as a 20-bit signed word. It re-emits that word to a serial DAC at a fixed higher output rate, framed by a latch-enable strobe. It sits between the audio source and the DAC at the top of the interpolation design.

## Interface
Parameters:
- `OUT_DIV`, default 584: CLK cycles between output words (about 4x the input frame rate at 100 MHz CLK). Must be ≥ 84.
- `SCLK_DIV`, default 4: CLK cycles per `clk_out` period (even, ≥ 2).

Ports:
- `CLK`, in, 1: single system clock (100 MHz). All logic runs in this domain.
- `RST`, in, 1: reset, synchronous and active-high.
- `serial_clk`, in, 1: I2S bit clock (about 2.8 MHz), asynchronous to `CLK`. Used as data, not as a clock.
- `lr_clk`, in, 1: I2S word-select. Low selects the left channel. Asynchronous.
- `serial_in`, in, 1: I2S data, MSB first, two's complement.
- `serial_out`, out, 1: DAC data, MSB first.
- `clk_out`, out, 1: DAC shift clock. Idle low.
- `LE`, out, 1: DAC frame / latch enable, active-low during a shift. Idle high.

## Operation
- **Input sync:** `serial_clk`, `lr_clk` and `serial_in` each pass through a 2-FF synchronizer. A third register per signal provides rising/falling edge detection on `serial_clk` and `lr_clk`.
- **Receiver FSM:** IDLE → SKIP → SHIFT → IDLE.
  - IDLE: a falling edge of `lr_clk` moves to SKIP.
  - SKIP: the first `serial_clk` rising edge is ignored (I2S one-bit delay), then move to SHIFT.
  - SHIFT: on each `serial_clk` rising edge, shift in `serial_in` (MSB first). After the 16th bit, return to IDLE and assert a 1-cycle `sample_valid`.
  - A rising `lr_clk` edge in SKIP or SHIFT aborts to IDLE and discards the partial word.
  - Right-channel data (`lr_clk` high) is ignored.
- **Hold stage (Q):** on `sample_valid`, `Q <= {sample[15:0], 4'b0000}`, a 20-bit signed, left-justified value. `Q` holds that value until the next valid sample; this is the ZOH.
- **Output timer:** a free-running counter from 0 to `OUT_DIV-1`. At wrap it issues an output tick.
- **Serializer:**
  - On a tick, snapshot `Q` into a 20-bit shift register and drive `LE` low.
  - Shift 20 bits MSB first. `serial_out` changes on the falling edge of `clk_out` and is stable at each `clk_out` rising edge.
  - After the 20th `clk_out` rising edge, `clk_out` returns low and `LE` returns high. The rising edge of `LE` latches the DAC.
- **ZOH behaviour:** each input sample is emitted repeatedly, about 4 times per input frame.
- **Reset values:** `Q` = 0, `serial_out` = 0, `clk_out` = 0, `LE` = 1, receiver FSM in IDLE, counters 0.

## Timing
- Synchronizer latency is 2 CLK cycles. `Q` updates no more than 4 CLK cycles after the 16th `serial_clk` rising edge reaches the pin.
- `serial_clk` high and low phases are each ≥ 3 CLK cycles.
- The first `clk_out` rising edge comes `SCLK_DIV` cycles after `LE` falls. A shift frame lasts `20*SCLK_DIV` + 1 cycles (81 at defaults).
- A new sample arriving mid-shift changes `Q` only; the word in flight is unaffected and the new sample appears from the next tick.
- A tick is never issued while `LE` is low, which is guaranteed by `OUT_DIV` ≥ 84.
- `RST` asserted mid-frame aborts both the receive and the shift on the next CLK edge and restores the reset values.

## Structure
- Shared package: `IN_W = 16`, `OUT_W = 20`, `PAD_W = 4`, and the receiver state enum.
- Sub-module `i2s_rx_left`: synchronizers, edge detect, receiver FSM. Outputs a 16-bit sample and `sample_valid`.
- The top level holds the `Q` register, output timer and serializer.

## Test plan
- Reset held for 500 ns → `LE` = 1, `clk_out` = 0, `serial_out` = 0, `Q` = 0. No `LE` falling edge while `RST` = 1.
- Left word 100 sent after `lr_clk` falls, with the one-bit delay → `Q` = 1600. The following 20-bit DAC frames carry 1600 MSB first, about 4 frames per input frame.
- Full sine table 0, ±1950 … ±10000, repeated twice → `Q` at each `LE` fall steps through value×16, including -10000 → -160000 and 0 → 0. Each value is repeated with no glitches or mixed words.
- Different data sent while `lr_clk` is high → ignored; `Q` is unchanged.
- `lr_clk` rises after 8 bits → partial word discarded; `Q` keeps its previous value.
- New sample completes while `LE` is low → the current frame is shifted intact with the old value, and the next frame carries the new value.

Source files
------------

// File: rtl/zoh_top_pipelined_pkg.sv
// Shared definitions for the zero-order-hold interpolation datapath.
// Contents: sample widths, receiver state encoding, and the helper that
// left-justifies a 16-bit input sample into the 20-bit DAC word.
package zoh_top_pipelined_pkg;

  localparam int IN_W  = 16;  // I2S sample width
  localparam int OUT_W = 20;  // DAC word width
  localparam int PAD_W = 4;   // low-order zero padding, OUT_W - IN_W

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_SKIP,
    RX_SHIFT
  } rx_state_t;

  // Left-justify: the 16-bit sample occupies the top bits, so the numeric
  // value is sample * 2**PAD_W with the sign preserved.
  function automatic logic signed [OUT_W-1:0] zoh_pad(input logic signed [IN_W-1:0] s);
    return {s, {PAD_W{1'b0}}};
  endfunction

endpackage

// File: rtl/i2s_rx_left.sv
// I2S left-channel receiver.
// Synchronizes the asynchronous I2S pins into the clk domain, detects edges
// on the bit clock and word select, and assembles one 16-bit left sample per
// frame (MSB first, one-bit delay after the word-select fall).
// Ports:
//   clk, rst            - system clock, synchronous active-high reset
//   serial_clk, lr_clk  - I2S bit clock / word select (async, sampled as data)
//   serial_in           - I2S data (async)
//   sample              - last completed left sample
//   sample_valid        - one-cycle strobe when sample is fresh
module i2s_rx_left
  import zoh_top_pipelined_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   serial_clk,
  input  logic                   lr_clk,
  input  logic                   serial_in,
  output logic signed [IN_W-1:0] sample,
  output logic                   sample_valid
);

  // [0],[1] form the 2-FF synchronizer; [2] is the previous synced value
  // used only for edge detection.
  logic [2:0] sclk_q;
  logic [2:0] lr_q;
  logic [1:0] din_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sclk_q <= '0;
      lr_q   <= '0;
      din_q  <= '0;
    end else begin
      sclk_q <= {sclk_q[1:0], serial_clk};
      lr_q   <= {lr_q[1:0], lr_clk};
      din_q  <= {din_q[0], serial_in};
    end
  end

  logic sclk_rise;
  logic lr_fall;
  logic lr_rise;
  logic din;

  assign sclk_rise = sclk_q[1] & ~sclk_q[2];
  assign lr_fall   = ~lr_q[1] & lr_q[2];
  assign lr_rise   = lr_q[1] & ~lr_q[2];
  assign din       = din_q[1];

  rx_state_t       state, state_n;
  logic [3:0]      cnt, cnt_n;
  logic [IN_W-1:0] sr, sr_n;
  logic            valid_n;

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= RX_IDLE;
      cnt          <= '0;
      sr           <= '0;
      sample_valid <= 1'b0;
    end else begin
      state        <= state_n;
      cnt          <= cnt_n;
      sr           <= sr_n;
      sample_valid <= valid_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    sr_n    = sr;
    valid_n = 1'b0;
    case (state)
      RX_IDLE: begin
        if (lr_fall) begin
          state_n = RX_SKIP;
          cnt_n   = '0;
        end
      end
      RX_SKIP: begin
        // First bit-clock rise after the word-select fall carries the
        // previous word's tail (I2S one-bit delay) and is dropped.
        if (lr_rise)        state_n = RX_IDLE;
        else if (sclk_rise) state_n = RX_SHIFT;
      end
      RX_SHIFT: begin
        if (lr_rise) begin
          // Word select went right before 16 bits arrived: discard.
          state_n = RX_IDLE;
        end else if (sclk_rise) begin
          sr_n = {sr[IN_W-2:0], din};
          if (cnt == 4'd15) begin
            state_n = RX_IDLE;
            valid_n = 1'b1;
            cnt_n   = '0;
          end else begin
            cnt_n = cnt + 4'd1;
          end
        end
      end
      default: state_n = RX_IDLE;
    endcase
  end

  // sr only changes inside SHIFT, so it is stable while sample_valid is high
  // and until the next frame starts shifting.
  assign sample = sr;

endmodule

// File: rtl/zoh_top_pipelined.sv
// Zero-order-hold interpolation datapath.
// Receives left-channel I2S samples, holds the latest one as a 20-bit
// left-justified word (Q), and re-sends Q to a serial DAC every OUT_DIV
// cycles as a 20-bit MSB-first frame framed by an active-low LE.
// Ports:
//   CLK, RST                       - system clock, synchronous active-high reset
//   serial_clk, lr_clk, serial_in  - I2S input (asynchronous)
//   serial_out                     - DAC data, changes on clk_out falling edge
//   clk_out                        - DAC shift clock, idle low
//   LE                             - DAC latch enable, low during a frame
module zoh_top_pipelined
  import zoh_top_pipelined_pkg::*;
#(
  parameter int OUT_DIV  = 584,
  parameter int SCLK_DIV = 4
) (
  input  logic CLK,
  input  logic RST,
  input  logic serial_clk,
  input  logic lr_clk,
  input  logic serial_in,
  output logic serial_out,
  output logic clk_out,
  output logic LE
);

  localparam int TW   = $clog2(OUT_DIV);
  localparam int PW   = $clog2(SCLK_DIV);
  localparam int HALF = SCLK_DIV / 2;

  localparam logic [TW-1:0] T_LAST  = TW'(OUT_DIV - 1);
  localparam logic [PW-1:0] PH_LAST = PW'(SCLK_DIV - 1);
  localparam logic [PW-1:0] PH_FALL = PW'(HALF - 1);
  localparam logic [4:0]    NBITS   = 5'(OUT_W);

  logic signed [IN_W-1:0] rx_sample;
  logic                   rx_valid;

  i2s_rx_left u_rx (
    .clk          (CLK),
    .rst          (RST),
    .serial_clk   (serial_clk),
    .lr_clk       (lr_clk),
    .serial_in    (serial_in),
    .sample       (rx_sample),
    .sample_valid (rx_valid)
  );

  logic signed [OUT_W-1:0] q;      // held sample (the ZOH)
  logic [TW-1:0]           tmr;    // output-rate timer
  logic                    tick;
  logic [OUT_W-1:0]        sr;     // word in flight; MSB drives serial_out
  logic [PW-1:0]           ph;     // phase within one clk_out period
  logic [4:0]              nb;     // clk_out rising edges issued this frame

  assign tick       = (tmr == T_LAST);
  assign serial_out = sr[OUT_W-1];

  always_ff @(posedge CLK) begin
    if (RST) begin
      q       <= '0;
      tmr     <= '0;
      sr      <= '0;
      ph      <= '0;
      nb      <= '0;
      clk_out <= 1'b0;
      LE      <= 1'b1;
    end else begin
      tmr <= tick ? '0 : tmr + 1'b1;

      // Q is independent of the serializer: a sample landing mid-frame
      // only affects the next snapshot.
      if (rx_valid) q <= zoh_pad(rx_sample);

      if (LE) begin
        if (tick) begin
          LE <= 1'b0;
          sr <= q;
          ph <= '0;
          nb <= '0;
        end
      end else if (nb == NBITS) begin
        // One cycle after the last rising edge: close the frame. The LE
        // rise latches the word in the DAC.
        LE      <= 1'b1;
        clk_out <= 1'b0;
        sr      <= '0;
        ph      <= '0;
        nb      <= '0;
      end else begin
        ph <= (ph == PH_LAST) ? '0 : ph + 1'b1;
        if (ph == PH_LAST) begin
          clk_out <= 1'b1;
          nb      <= nb + 5'd1;
        end else if (ph == PH_FALL && nb != 5'd0) begin
          // Falling edge: advance to the next bit so it is settled for a
          // full half period before the following rising edge.
          clk_out <= 1'b0;
          sr      <= {sr[OUT_W-2:0], 1'b0};
        end
      end
    end
  end

endmodule

// File: tb/tb_zoh_top_pipelined.sv
// Directed testbench for zoh_top_pipelined. Drives I2S frames (6-cycle bit
// clock, 64 bit clocks per frame = 384 cycles) with OUT_DIV = 96 so that each
// input frame yields exactly four DAC frames, and decodes the DAC frames.
module tb_zoh_top_pipelined;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  logic serial_clk = 1'b0;
  logic lr_clk = 1'b1;
  logic serial_in = 1'b0;
  logic serial_out;
  logic clk_out;
  logic LE;

  zoh_top_pipelined #(.OUT_DIV(96), .SCLK_DIV(4)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .serial_clk (serial_clk),
    .lr_clk     (lr_clk),
    .serial_in  (serial_in),
    .serial_out (serial_out),
    .clk_out    (clk_out),
    .LE         (LE)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;

  // DAC frame decoder, sampled on the inactive edge.
  logic [19:0] frames[$];
  int          fbits[$];
  logic [19:0] cap = '0;
  int          nbits = 0;
  logic        prev_le = 1'b1;
  logic        prev_ck = 1'b0;
  int          le_rst_falls = 0;

  always @(negedge CLK) begin
    if (prev_le && !LE) begin
      cap   <= '0;
      nbits <= 0;
      if (RST) le_rst_falls <= le_rst_falls + 1;
    end else if (!LE && !prev_ck && clk_out) begin
      cap   <= {cap[18:0], serial_out};
      nbits <= nbits + 1;
    end
    if (!prev_le && LE) begin
      frames.push_back(cap);
      fbits.push_back(nbits);
    end
    prev_le <= LE;
    prev_ck <= clk_out;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic sbit(input logic lr, input logic d);
    lr_clk     = lr;
    serial_in  = d;
    serial_clk = 1'b0;
    repeat (3) @(negedge CLK);
    serial_clk = 1'b1;
    repeat (3) @(negedge CLK);
  endtask

  // left_slots: bit clocks spent with lr_clk low (32 for a full frame).
  task automatic send_frame(input logic [15:0] l, input logic [15:0] r, input int left_slots);
    for (int i = 0; i < left_slots; i++)
      sbit(1'b0, (i >= 1 && i <= 16) ? l[4'(16 - i)] : 1'b0);
    for (int i = 0; i < 32; i++)
      sbit(1'b1, (i >= 1 && i <= 16) ? r[4'(16 - i)] : 1'b0);
  endtask

  task automatic wait_le_fall(input string tag);
    logic p;
    logic ok;
    ok = 1'b0;
    p  = LE;
    for (int i = 0; i < 300; i++) begin
      @(negedge CLK);
      if (p && !LE) begin
        ok = 1'b1;
        break;
      end
      p = LE;
    end
    chk(tag, {31'b0, ok}, 32'd1);
  endtask

  function automatic logic [31:0] w20(input int v);
    logic [19:0] t;
    t = 20'(v * 16);
    return {12'b0, t};
  endfunction

  int tbl[16] = '{0, 1950, 5556, 8315, 10000, 8315, 5556, 1950,
                  0, -1950, -5556, -8315, -10000, -8315, -5556, -1950};

  initial begin
    int          idx;
    int          bad;
    int          badlen;
    int          n0;
    logic [19:0] runs_v[$];
    int          runs_n[$];
    logic        seen;
    logic        le_at;

    // Reset for 500 ns.
    repeat (50) @(negedge CLK);
    chk("rst_le", {31'b0, LE}, 32'd1);
    chk("rst_clk_out", {31'b0, clk_out}, 32'd0);
    chk("rst_serial_out", {31'b0, serial_out}, 32'd0);
    chk("rst_q", {12'b0, dut.q}, 32'd0);
    chk("rst_le_falls", le_rst_falls, 0);
    RST = 1'b0;
    repeat (10) @(negedge CLK);

    // Word 100 -> Q = 1600, then frames repeat it.
    send_frame(16'd100, 16'h1234, 32);
    chk("q_100", {12'b0, dut.q}, w20(100));
    idx = frames.size();
    send_frame(16'd100, 16'hfffb, 32);
    send_frame(16'd100, 16'hfffb, 32);
    n0 = frames.size() - idx;
    chk("frames_per_2_inputs_in_range", {31'b0, (n0 >= 7 && n0 <= 9)}, 32'd1);
    bad = 0;
    for (int i = idx; i < frames.size(); i++)
      if (frames[i] !== 20'd1600 || fbits[i] != 20) bad++;
    chk("frames_100_bad", bad, 0);

    // Sine table, twice.
    idx = frames.size();
    for (int k = 0; k < 32; k++) begin
      send_frame(16'(tbl[k % 16]), ~16'(tbl[k % 16]), 32);
      chk($sformatf("q_sine_%0d", k), {12'b0, dut.q}, w20(tbl[k % 16]));
    end
    repeat (200) @(negedge CLK);
    bad = 0;
    for (int i = idx; i < frames.size(); i++) begin
      if (fbits[i] != 20) bad++;
      if (runs_v.size() == 0 || frames[i] !== runs_v[$]) begin
        runs_v.push_back(frames[i]);
        runs_n.push_back(1);
      end else begin
        runs_n[runs_n.size() - 1]++;
      end
    end
    chk("sine_bitcount_bad", bad, 0);
    while (runs_v.size() > 0 && runs_v[0] === 20'd1600) begin
      void'(runs_v.pop_front());
      void'(runs_n.pop_front());
    end
    chk("sine_run_count", runs_v.size(), 32);
    bad    = 0;
    badlen = 0;
    for (int k = 0; k < 32; k++) begin
      if ({12'b0, runs_v[k]} !== w20(tbl[k % 16])) bad++;
      if (k > 0 && k < 31 && (runs_n[k] < 3 || runs_n[k] > 5)) badlen++;
    end
    chk("sine_seq_bad", bad, 0);
    chk("sine_run_len_bad", badlen, 0);
    chk("sine_min_frame", {12'b0, runs_v[12]}, 32'h000d8f00);
    chk("sine_zero_frame", {12'b0, runs_v[8]}, 32'd0);

    // Right-channel data must not reach Q.
    send_frame(16'd300, 16'(-7777), 32);
    chk("q_left_only", {12'b0, dut.q}, w20(300));
    send_frame(16'd300, 16'h7fff, 32);
    chk("q_right_ignored", {12'b0, dut.q}, w20(300));

    // lr_clk rises after 8 data bits: partial word dropped.
    send_frame(16'd1234, 16'd55, 9);
    chk("q_abort_keeps", {12'b0, dut.q}, w20(300));
    send_frame(16'hfffe, 16'd0, 32);
    chk("q_after_abort", {12'b0, dut.q}, w20(-2));

    // New sample lands while LE is low: that frame keeps the old word.
    wait_le_fall("mid_le_fall_seen");
    n0 = frames.size();
    repeat (33) @(negedge CLK);
    seen  = 1'b0;
    le_at = 1'b1;
    fork
      send_frame(16'd777, 16'd0, 32);
      begin
        for (int i = 0; i < 500; i++) begin
          @(negedge CLK);
          if (dut.q !== 20'hfffe0) begin
            seen  = 1'b1;
            le_at = LE;
            break;
          end
        end
      end
    join
    repeat (300) @(negedge CLK);
    chk("mid_q_changed", {31'b0, seen}, 32'd1);
    chk("mid_le_low_at_change", {31'b0, le_at}, 32'd0);
    chk("mid_frame_old", {12'b0, frames[n0 + 1]}, w20(-2));
    chk("mid_frame_new", {12'b0, frames[n0 + 2]}, w20(777));

    // Reset in the middle of a frame.
    wait_le_fall("rst_mid_le_fall_seen");
    repeat (30) @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    chk("rst_mid_le", {31'b0, LE}, 32'd1);
    chk("rst_mid_clk_out", {31'b0, clk_out}, 32'd0);
    chk("rst_mid_serial_out", {31'b0, serial_out}, 32'd0);
    chk("rst_mid_q", {12'b0, dut.q}, 32'd0);
    RST = 1'b0;
    repeat (5) @(negedge CLK);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
